// File: rtl/data_memory_stage.sv
// Memory stage behind the ALU: byte-addressed little-endian load/store on a local RAM,
// with a fixed three-state pipeline so every op (load, store, pass-through) completes with equal latency.
module data_memory_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        mem_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t state, state_next;

  logic [31:0] addr_q, wdata_q;
  logic        re_q, we_q, unsigned_q;
  logic [1:0]  size_q;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata;

  logic [ADDR_W-3:0] word_idx;
  logic              access_err;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       rdata_shift;
  logic [31:0]       load_val;
  logic [31:0]       result_next;

  assign word_idx = addr_q[ADDR_W-1:2];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCESS;
      ACCESS:  state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so later ALU traffic cannot disturb the op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
    end else if (state == IDLE && start) begin
      addr_q     <= addr;
      wdata_q    <= wdata;
      re_q       <= mem_re;
      we_q       <= mem_we;
      size_q     <= size;
      unsigned_q <= load_unsigned;
    end
  end

  always_comb begin
    access_err = (re_q || we_q) &&
                 ((size_q == 2'b01 && addr_q[0]) ||
                  (size_q == 2'b10 && addr_q[1:0] != 2'b00) ||
                  (size_q == 2'b11) ||
                  (re_q && we_q));
    byte_en   = 4'b0000;
    wdata_rep = wdata_q;
    case (size_q)
      2'b00: begin
        byte_en   = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // RAM has no reset: contents survive rst, only the control path is cleared.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      if (we_q && !access_err) begin
        if (byte_en[0]) mem[word_idx][7:0]   <= wdata_rep[7:0];
        if (byte_en[1]) mem[word_idx][15:8]  <= wdata_rep[15:8];
        if (byte_en[2]) mem[word_idx][23:16] <= wdata_rep[23:16];
        if (byte_en[3]) mem[word_idx][31:24] <= wdata_rep[31:24];
      end
      rdata <= mem[word_idx];
    end
  end

  always_comb begin
    rdata_shift = rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_val = unsigned_q ? {24'b0, rdata_shift[7:0]}
                                     : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   load_val = unsigned_q ? {16'b0, rdata_shift[15:0]}
                                     : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_val = rdata;
    endcase
    if (access_err || we_q) result_next = '0;
    else if (re_q)          result_next = load_val;
    else                    result_next = addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result  <= '0;
      done    <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      done <= (state == RESPOND);
      if (state == RESPOND) begin
        result  <= result_next;
        mem_err <= access_err;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed bench for data_memory_stage: a byte-array reference model checked every cycle,
// plus literal expectations on each directed op.
module tb_data_memory_stage;

  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        mem_err;

  int vectors = 0;
  int miscompares = 0;

  data_memory_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .wdata(wdata),
    .mem_re(mem_re), .mem_we(mem_we), .size(size), .load_unsigned(load_unsigned),
    .result(result), .done(done), .busy(busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Reference model: memory as a flat byte array, op evaluated one edge after acceptance.
  logic [7:0]  mem_b [2**ADDR_W];
  int          left = 0;
  logic        exp_done = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_result = '0;
  logic [31:0] p_addr, p_wdata, p_res;
  logic        p_re, p_we, p_lu, p_err;
  logic [1:0]  p_size;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      left = 0; exp_done = 0; exp_busy = 0; exp_err = 0; exp_result = 0;
    end else begin
      exp_done = 1'b0;
      if (left > 0) begin
        left = left - 1;
        if (left == 1) begin
          int a, nb;
          logic [31:0] v;
          a  = int'(p_addr) % (2**ADDR_W);
          nb = 1 << p_size;
          p_err = (p_re || p_we) && ((p_size == 1 && a % 2 != 0) || (p_size == 2 && a % 4 != 0)
                  || p_size == 3 || (p_re && p_we));
          if (p_err) p_res = 0;
          else if (p_we) begin
            for (int k = 0; k < nb; k++) mem_b[a + k] = p_wdata[8*k +: 8];
            p_res = 0;
          end else if (p_re) begin
            v = 0;
            for (int k = 0; k < nb; k++) v = v | (32'(mem_b[a + k]) << (8 * k));
            if (!p_lu && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            p_res = v;
          end else p_res = p_addr;
        end
        if (left == 0) begin
          exp_done = 1'b1; exp_busy = 1'b0; exp_result = p_res; exp_err = p_err;
        end
      end else if (start) begin
        p_addr = addr; p_wdata = wdata; p_re = mem_re; p_we = mem_we;
        p_size = size; p_lu = load_unsigned;
        left = 2; exp_busy = 1'b1;
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check32("model done", 32'(done), 32'(exp_done));
      check32("model busy", 32'(busy), 32'(exp_busy));
      check32("model result", result, exp_result);
      if (exp_done) check32("model mem_err", 32'(mem_err), 32'(exp_err));
    end
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] wd,
                        input logic re, input logic we, input logic [1:0] sz, input logic lu,
                        input logic [31:0] want, input logic want_err);
    int n = 0;
    logic got = 1'b0;
    @(negedge clk);
    addr = a; wdata = wd; mem_re = re; mem_we = we; size = sz; load_unsigned = lu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n < 6 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("[TB] FAIL %s timeout: got no done, expected done", name);
    end else begin
      check32({name, " result"}, result, want);
      check32({name, " mem_err"}, 32'(mem_err), 32'(want_err));
      check32({name, " latency"}, 32'(n), 32'd2);
    end
  endtask

  initial begin
    int dones;
    repeat (2) @(negedge clk);
    check32("reset done", 32'(done), 32'd0);
    check32("reset busy", 32'(busy), 32'd0);
    check32("reset result", result, 32'd0);
    check32("reset mem_err", 32'(mem_err), 32'd0);
    rst = 1'b1;

    run_op("pass", 32'h0000_1234, 32'h0, 0, 0, 2'b10, 0, 32'h0000_1234, 0);
    run_op("SW",   32'h10, 32'hDEAD_BEEF, 0, 1, 2'b10, 0, 32'h0, 0);
    run_op("LW",   32'h10, 32'h0, 1, 0, 2'b10, 0, 32'hDEAD_BEEF, 0);
    run_op("LB",   32'h13, 32'h0, 1, 0, 2'b00, 0, 32'hFFFF_FFDE, 0);
    run_op("LBU",  32'h13, 32'h0, 1, 0, 2'b00, 1, 32'h0000_00DE, 0);
    run_op("SH",   32'h12, 32'h0000_1234, 0, 1, 2'b01, 0, 32'h0, 0);
    run_op("LW2",  32'h10, 32'h0, 1, 0, 2'b10, 0, 32'h1234_BEEF, 0);
    run_op("LH",   32'h10, 32'h0, 1, 0, 2'b01, 0, 32'hFFFF_BEEF, 0);
    run_op("LHU",  32'h12, 32'h0, 1, 0, 2'b01, 1, 32'h0000_1234, 0);
    run_op("LWmis", 32'h11, 32'h0, 1, 0, 2'b10, 0, 32'h0, 1);
    run_op("SHmis", 32'h13, 32'h0000_AAAA, 0, 1, 2'b01, 0, 32'h0, 1);
    run_op("SZ11", 32'h10, 32'h0, 1, 0, 2'b11, 0, 32'h0, 1);
    run_op("REWE", 32'h10, 32'h5555_5555, 1, 1, 2'b10, 0, 32'h0, 1);
    run_op("LW3",  32'h10, 32'h0, 1, 0, 2'b10, 0, 32'h1234_BEEF, 0);
    run_op("SW20", 32'h20, 32'h1122_3344, 0, 1, 2'b10, 0, 32'h0, 0);
    run_op("SB21", 32'h21, 32'h0000_00AB, 0, 1, 2'b00, 0, 32'h0, 0);
    run_op("LW20", 32'h20, 32'h0, 1, 0, 2'b10, 0, 32'h1122_AB44, 0);
    run_op("LH22", 32'h22, 32'h0, 1, 0, 2'b01, 0, 32'h0000_1122, 0);

    // Second start one cycle after the first must be ignored.
    @(negedge clk);
    addr = 32'h55; mem_re = 0; mem_we = 0; size = 2'b10; start = 1'b1;
    @(negedge clk);
    addr = 32'h66;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) begin
        dones++;
        check32("double start result", result, 32'h55);
      end
      @(negedge clk);
    end
    check32("double start done count", 32'(dones), 32'd1);

    run_op("SBalias", 32'h410, 32'h0000_0077, 0, 1, 2'b00, 0, 32'h0, 0);
    run_op("LWalias", 32'h10, 32'h0, 1, 0, 2'b10, 0, 32'h1234_BE77, 0);

    // Reset asserted while a load sits in ACCESS.
    @(negedge clk);
    addr = 32'h10; mem_re = 1; mem_we = 0; size = 2'b10; load_unsigned = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    #1;
    check32("midrst done", 32'(done), 32'd0);
    check32("midrst busy", 32'(busy), 32'd0);
    check32("midrst result", result, 32'd0);
    check32("midrst mem_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check32("midrst no done", 32'(dones), 32'd0);
    run_op("LWpost", 32'h10, 32'h0, 1, 0, 2'b10, 0, 32'h1234_BE77, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
